ntt_sched: RTL and testbench

//  Sequencer/arbiter in front of the dual-lane pipelined NTT (ntt).
//  Two clients each own a coefficient bank. The block grants the NTT pipeline to one client at a time, round-robin.
//  It streams that client's PAIR_CNT coefficient pairs into the pipeline, then writes the PAIR_CNT result pairs back.
//  It holds in_en low until the pipeline drains, so per-stage counters restart clean, and reports done per client.

---
 rtl/ntt_pkg.sv | 20 ++
 rtl/ntt_sched_rr_arb2.sv | 33 +++
 rtl/ntt_sched.sv | 128 ++++++++++++
 tb/tb_ntt_sched.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared sizing constants and FSM encoding for the NTT front-end scheduler.
package ntt_pkg;

    localparam int PAIR_CNT = 128;
    localparam int ADDR_W   = $clog2(PAIR_CNT);
    localparam int RD_LAT   = 1;
    localparam int TIMEOUT  = 1023;

    // One extra bit so a full count of PAIR_CNT is representable.
    localparam int CNT_W    = ADDR_W + 1;
    localparam int TO_W     = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN,
        S_DONE
    } sched_state_t;

endpackage

// File: rtl/ntt_sched_rr_arb2.sv
// Two-way round-robin arbiter: a sole requester always wins; on a tie the
// client that was not served by the most recently finished job wins.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       last_idx,
    output logic [1:0] gnt
);

    // Index of the client favoured when both request.
    logic prio;

    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (update) begin
            prio <= ~last_idx;
        end
    end

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = prio ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/ntt_sched.sv
// Grants the dual-lane NTT pipeline to one of two clients, streams that client's
// coefficient pairs in, writes the result pairs back and waits for the pipe to drain.
module ntt_sched
    import ntt_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    output logic [1:0]        gnt,
    output logic              busy,
    output logic [1:0]        done,
    output logic              err,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_bank,
    output logic              ntt_in_en,
    input  logic              ntt_out_en,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_bank
);

    // Handshake: req is a level a client holds until it sees its gnt bit; gnt is
    // then held for the whole job and drops after the single-cycle done pulse.
    // Request changes while busy are ignored; a req seen in IDLE starts a job.

    sched_state_t      state;
    sched_state_t      state_nx;
    logic [CNT_W-1:0]  rd_cnt;
    logic [CNT_W-1:0]  wr_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [RD_LAT-1:0] in_chain;
    logic [1:0]        arb_gnt;
    logic              arb_update;
    logic              rd_last;
    logic              wr_full;
    logic              drain_ok;
    logic              drain_to;
    logic              job_active;
    logic              out_stray;
    logic              out_extra;

    assign arb_update = (state == S_DONE);

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .update   (arb_update),
        .last_idx (gnt[1]),
        .gnt      (arb_gnt)
    );

    assign job_active = (state == S_FEED) || (state == S_DRAIN);
    assign rd_last    = (rd_cnt == CNT_W'(PAIR_CNT - 1));
    assign wr_full    = (wr_cnt == CNT_W'(PAIR_CNT));
    assign drain_ok   = wr_full && !ntt_out_en;
    assign drain_to   = (to_cnt == TO_W'(TIMEOUT));

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (req != 2'b00) state_nx = S_FEED;
            S_FEED:  if (rd_last) state_nx = S_DRAIN;
            S_DRAIN: if (drain_ok || drain_to) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign busy      = (state != S_IDLE);
    assign rd_en     = (state == S_FEED);
    assign rd_addr   = rd_cnt[ADDR_W-1:0];
    assign rd_bank   = gnt[1];
    assign wr_bank   = gnt[1];
    assign ntt_in_en = in_chain[RD_LAT-1];
    assign wr_en     = ntt_out_en && job_active && !wr_full;
    assign wr_addr   = wr_cnt[ADDR_W-1:0];
    assign done      = (state == S_DONE) ? gnt : 2'b00;

    // Output data arriving with no job, or beyond the last pair, is never written.
    assign out_stray = ntt_out_en && !job_active;
    assign out_extra = ntt_out_en && job_active && wr_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            gnt      <= 2'b00;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            to_cnt   <= '0;
            in_chain <= '0;
            err      <= 1'b0;
        end else begin
            state       <= state_nx;
            in_chain[0] <= rd_en;
            for (int i = 1; i < RD_LAT; i++) begin
                in_chain[i] <= in_chain[i-1];
            end

            if (state == S_IDLE) begin
                gnt <= arb_gnt;
            end else if (state == S_DONE) begin
                gnt <= 2'b00;
            end

            if (state == S_IDLE) begin
                rd_cnt <= '0;
                wr_cnt <= '0;
            end else begin
                if (rd_en) rd_cnt <= rd_cnt + 1'b1;
                if (wr_en) wr_cnt <= wr_cnt + 1'b1;
            end

            // Counts DRAIN cycles from zero; DRAIN lasts at most TIMEOUT+1 cycles.
            if (state == S_DRAIN) begin
                to_cnt <= to_cnt + 1'b1;
            end else begin
                to_cnt <= '0;
            end

            if (out_stray || out_extra || (state == S_DRAIN && drain_to && !drain_ok)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ntt_sched.sv
// Bench for ntt_sched: a behavioural NTT latency model feeds ntt_out_en, every
// cycle is captured into a trace, and each scenario checks the trace against rules.
module tb_ntt_sched;
    import ntt_pkg::*;

    logic              clk;
    logic              rst;
    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              busy;
    logic [1:0]        done;
    logic              err;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_bank;
    logic              ntt_in_en;
    logic              ntt_out_en;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_bank;

    int n_cmp;
    int n_fail;

    // NTT model: mode 0 = fixed latency, 1 = burst stretched by 2 cycles, 2 = silent.
    int          lat;
    int          ntt_mode;
    logic        pulse;
    logic        model_out;
    logic [63:0] pipe;
    int          last_client;

    ntt_sched dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .gnt        (gnt),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_bank    (rd_bank),
        .ntt_in_en  (ntt_in_en),
        .ntt_out_en (ntt_out_en),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_bank    (wr_bank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) pipe <= '0;
        else     pipe <= {pipe[62:0], ntt_in_en};
    end

    always_comb begin
        model_out = 1'b0;
        if (ntt_mode == 0)      model_out = pipe[lat-1];
        else if (ntt_mode == 1) model_out = pipe[lat-1] | pipe[lat] | pipe[lat+1];
    end

    assign ntt_out_en = model_out | pulse;

    typedef struct {
        logic [1:0]        gnt;
        logic              busy;
        logic [1:0]        done;
        logic              err;
        logic              rd_en;
        logic [ADDR_W-1:0] rd_addr;
        logic              rd_bank;
        logic              in_en;
        logic              out_en;
        logic              wr_en;
        logic [ADDR_W-1:0] wr_addr;
        logic              wr_bank;
    } obs_t;

    obs_t              tr[$];
    logic [ADDR_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] rd_q[$];
    logic [ADDR_W-1:0] wr_q[$];
    logic [1:0]        done_q[$];
    logic [1:0]        gnt_q[$];
    int rd_bursts, in_bursts, in_lag_bad, bank_bad;
    int last_rd_idx, last_wr_idx, last_out_idx, done_idx, err_idx, out_cnt, out129_idx;

    // Sample all outputs mid-cycle, away from the active edge.
    task automatic sample();
        obs_t o;
        @(negedge clk);
        o.gnt = gnt;         o.busy = busy;       o.done = done;     o.err = err;
        o.rd_en = rd_en;     o.rd_addr = rd_addr; o.rd_bank = rd_bank;
        o.in_en = ntt_in_en; o.out_en = ntt_out_en;
        o.wr_en = wr_en;     o.wr_addr = wr_addr; o.wr_bank = wr_bank;
        tr.push_back(o);
    endtask

    task automatic run_job(input int budget, input bit hold, output bit finished);
        finished = 1'b0;
        for (int c = 0; c < budget; c++) begin
            sample();
            if (!hold) req = req & ~tr[tr.size()-1].gnt;
            if (tr[tr.size()-1].done != 2'b00) begin
                finished = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = 2'b00; pulse = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_client = 1;
    endtask

    // Winner rule: sole requester wins, a tie goes to the client not served last.
    function automatic logic [1:0] pick(input logic [1:0] r, input int last);
        if (r == 2'b01) return 2'b01;
        if (r == 2'b10) return 2'b10;
        if (r == 2'b11) return (last == 0) ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    task automatic fill_exp();
        exp_q.delete();
        for (int i = 0; i < PAIR_CNT; i++) exp_q.push_back(ADDR_W'(i));
    endtask

    task automatic analyse();
        obs_t prev;
        prev = '{default: '0};
        rd_q.delete(); wr_q.delete(); done_q.delete(); gnt_q.delete();
        rd_bursts = 0; in_bursts = 0; in_lag_bad = 0; bank_bad = 0; out_cnt = 0;
        last_rd_idx = -1; last_wr_idx = -1; last_out_idx = -1;
        done_idx = -1; err_idx = -1; out129_idx = -1;
        for (int i = 0; i < tr.size(); i++) begin
            if (tr[i].rd_en) begin
                rd_q.push_back(tr[i].rd_addr);
                last_rd_idx = i;
                if (!prev.rd_en) rd_bursts++;
            end
            if (tr[i].in_en && !prev.in_en) in_bursts++;
            if (i >= RD_LAT && tr[i].in_en !== tr[i-RD_LAT].rd_en) in_lag_bad++;
            if (tr[i].wr_en) begin
                wr_q.push_back(tr[i].wr_addr);
                last_wr_idx = i;
            end
            if (tr[i].out_en) begin
                out_cnt++;
                last_out_idx = i;
                if (out_cnt == PAIR_CNT + 1) out129_idx = i;
            end
            if (tr[i].done != 2'b00) begin
                done_q.push_back(tr[i].done);
                if (done_idx < 0) done_idx = i;
            end
            if (tr[i].err && err_idx < 0) err_idx = i;
            if (tr[i].gnt != 2'b00 && tr[i].gnt != prev.gnt) gnt_q.push_back(tr[i].gnt);
            if (tr[i].gnt != 2'b00 && (tr[i].rd_bank !== tr[i].gnt[1] || tr[i].wr_bank !== tr[i].gnt[1]))
                bank_bad++;
            prev = tr[i];
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({gnt, busy, done, err, rd_en, rd_addr, rd_bank, ntt_in_en, wr_en, wr_addr, wr_bank} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got gnt=%b busy=%b done=%b err=%b rd_en=%b wr_en=%b, expected all 0",
                     gnt, busy, done, err, rd_en, wr_en);
        end
        rst = 1'b0;
        last_client = 1;
    endtask

    task automatic test_single();
        bit fin;
        lat = 40; ntt_mode = 0;
        @(negedge clk);
        tr.delete();
        req = 2'b01;
        run_job(600, 1'b0, fin);
        analyse();
        n_cmp++; if (!fin) begin n_fail++; $display("FAIL single_timeout: no done within 600 cycles"); end
        n_cmp++; if (tr[0].gnt !== 2'b01 || tr[0].rd_en !== 1'b1) begin
            n_fail++; $display("FAIL single_grant_latency: gnt=%b rd_en=%b, expected 01/1", tr[0].gnt, tr[0].rd_en); end
        n_cmp++; if (gnt_q.size() != 1 || gnt_q[0] !== 2'b01) begin
            n_fail++; $display("FAIL single_gnt: %0d grants first=%b, expected 1 of 01", gnt_q.size(), gnt_q[0]); end
        fill_exp();
        n_cmp++; if (rd_q.size() != PAIR_CNT) begin
            n_fail++; $display("FAIL single_rd_count: got %0d expected %0d", rd_q.size(), PAIR_CNT); end
        for (int i = 0; i < rd_q.size() && i < PAIR_CNT; i++) begin
            n_cmp++; if (rd_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL single_rd_addr[%0d]: got %0d expected %0d", i, rd_q[i], exp_q[i]); end
        end
        n_cmp++; if (rd_bursts != 1 || in_bursts != 1 || in_lag_bad != 0) begin
            n_fail++; $display("FAIL single_in_en: rd bursts %0d in bursts %0d lag errors %0d, expected 1/1/0",
                               rd_bursts, in_bursts, in_lag_bad); end
        n_cmp++; if (wr_q.size() != PAIR_CNT) begin
            n_fail++; $display("FAIL single_wr_count: got %0d expected %0d", wr_q.size(), PAIR_CNT); end
        for (int i = 0; i < wr_q.size() && i < PAIR_CNT; i++) begin
            n_cmp++; if (wr_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL single_wr_addr[%0d]: got %0d expected %0d", i, wr_q[i], exp_q[i]); end
        end
        n_cmp++; if (done_q.size() != 1 || done_q[0] !== 2'b01) begin
            n_fail++; $display("FAIL single_done: %0d pulses first=%b, expected 1 of 01", done_q.size(), done_q[0]); end
        n_cmp++; if (done_idx != last_wr_idx + 2) begin
            n_fail++; $display("FAIL single_done_time: done at %0d expected %0d", done_idx, last_wr_idx + 2); end
        n_cmp++; if (err_idx != -1 || bank_bad != 0) begin
            n_fail++; $display("FAIL single_err_bank: err at %0d bank errors %0d, expected none", err_idx, bank_bad); end
        req = 2'b00;
        last_client = 0;
    endtask

    task automatic test_round_robin();
        bit fin;
        int fin_cnt, gaps, bad_gap, bad_start, run;
        logic [1:0] exp_seq [3];
        do_reset();
        lat = $urandom_range(1, 60); ntt_mode = 0;
        @(negedge clk);
        tr.delete();
        fin_cnt = 0;
        for (int j = 0; j < 3; j++) begin
            exp_seq[j] = pick(2'b11, last_client);
            last_client = exp_seq[j][1] ? 1 : 0;
        end
        req = 2'b11;
        for (int j = 0; j < 3; j++) begin
            run_job(400, 1'b1, fin);
            if (fin) fin_cnt++;
        end
        req = 2'b00;
        analyse();
        n_cmp++; if (fin_cnt != 3) begin n_fail++; $display("FAIL rr_jobs: got %0d jobs expected 3", fin_cnt); end
        for (int j = 0; j < 3; j++) begin
            n_cmp++; if (gnt_q.size() != 3 || gnt_q[j] !== exp_seq[j] || done_q.size() != 3 || done_q[j] !== exp_seq[j]) begin
                n_fail++; $display("FAIL rr_order[%0d]: gnt=%b done=%b expected %b", j, gnt_q[j], done_q[j], exp_seq[j]); end
        end
        gaps = 0; bad_gap = 0; bad_start = 0; run = 0;
        for (int i = 0; i < tr.size(); i++) begin
            if (!tr[i].busy) run++;
            else begin
                if (run > 0) begin
                    gaps++;
                    if (run != 1) bad_gap++;
                    if (!tr[i].rd_en || tr[i].rd_addr !== '0) bad_start++;
                end
                run = 0;
            end
        end
        n_cmp++; if (gaps != 2 || bad_gap != 0 || bad_start != 0) begin
            n_fail++; $display("FAIL rr_gaps: gaps %0d bad lengths %0d bad starts %0d, expected 2/0/0", gaps, bad_gap, bad_start); end
    endtask

    task automatic test_long_outen();
        bit fin;
        logic [1:0] c;
        do_reset();
        lat = $urandom_range(1, 50); ntt_mode = 1;
        c = $urandom_range(0, 1) ? 2'b10 : 2'b01;
        @(negedge clk);
        tr.delete();
        req = c;
        run_job(600, 1'b0, fin);
        analyse();
        n_cmp++; if (!fin) begin n_fail++; $display("FAIL long_timeout: no done within 600 cycles"); end
        n_cmp++; if (out_cnt != PAIR_CNT + 2 || wr_q.size() != PAIR_CNT) begin
            n_fail++; $display("FAIL long_counts: out_en %0d writes %0d, expected %0d/%0d", out_cnt, wr_q.size(), PAIR_CNT + 2, PAIR_CNT); end
        n_cmp++; if (out129_idx < 0 || err_idx != out129_idx + 1) begin
            n_fail++; $display("FAIL long_err_time: err rose at %0d expected %0d", err_idx, out129_idx + 1); end
        n_cmp++; if (done_q.size() != 1 || done_q[0] !== c || done_idx != last_out_idx + 2) begin
            n_fail++; $display("FAIL long_done: done=%b at %0d expected %b at %0d", done_q[0], done_idx, c, last_out_idx + 2); end
        ntt_mode = 0;
    endtask

    task automatic test_timeout();
        bit fin;
        do_reset();
        lat = 40; ntt_mode = 2;
        @(negedge clk);
        tr.delete();
        req = 2'b10;
        run_job(1400, 1'b0, fin);
        analyse();
        n_cmp++; if (!fin) begin n_fail++; $display("FAIL to_finish: no done within 1400 cycles"); end
        n_cmp++; if (done_idx != last_rd_idx + TIMEOUT + 2) begin
            n_fail++; $display("FAIL to_drain_len: drain cycles %0d expected %0d", done_idx - last_rd_idx - 1, TIMEOUT + 1); end
        n_cmp++; if (done_idx < 1 || tr[done_idx].err !== 1'b1 || tr[done_idx-1].err !== 1'b0) begin
            n_fail++; $display("FAIL to_err: err first at %0d expected %0d", err_idx, done_idx); end
        n_cmp++; if (wr_q.size() != 0 || done_q.size() != 1 || done_q[0] !== 2'b10) begin
            n_fail++; $display("FAIL to_wr_done: writes %0d done=%b, expected 0 and 10", wr_q.size(), done_q[0]); end
        ntt_mode = 0;
    endtask

    task automatic test_reset_midjob();
        bit fin;
        bit found;
        int stray_done;
        do_reset();
        lat = 40; ntt_mode = 0;
        @(negedge clk);
        req = 2'b01;
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            sample();
            req = req & ~tr[tr.size()-1].gnt;
            if (tr[tr.size()-1].rd_en && tr[tr.size()-1].rd_addr == ADDR_W'(50)) begin
                found = 1'b1;
                break;
            end
        end
        n_cmp++; if (!found) begin n_fail++; $display("FAIL rstmid_reach: FEED cycle 50 not reached"); end
        rst = 1'b1;
        sample();
        n_cmp++;
        if ({gnt, busy, done, err, rd_en, rd_addr, ntt_in_en, wr_en, wr_addr, rd_bank, wr_bank} !== '0) begin
            n_fail++; $display("FAIL rstmid_outputs: gnt=%b busy=%b rd_en=%b in_en=%b wr_en=%b, expected all 0",
                               gnt, busy, rd_en, ntt_in_en, wr_en); end
        rst = 1'b0;
        last_client = 1;
        stray_done = 0;
        for (int c = 0; c < 3; c++) begin
            sample();
            if (tr[tr.size()-1].done != 2'b00 || tr[tr.size()-1].in_en) stray_done++;
        end
        n_cmp++; if (stray_done != 0) begin n_fail++; $display("FAIL rstmid_quiet: %0d active cycles after reset, expected 0", stray_done); end
        tr.delete();
        req = 2'b10;
        run_job(600, 1'b0, fin);
        analyse();
        fill_exp();
        n_cmp++; if (!fin || gnt_q.size() != 1 || gnt_q[0] !== 2'b10 || done_q.size() != 1 || done_q[0] !== 2'b10) begin
            n_fail++; $display("FAIL rstmid_job: fin=%0d gnt=%b done=%b expected 1/10/10", fin, gnt_q[0], done_q[0]); end
        n_cmp++; if (rd_q.size() != PAIR_CNT || wr_q.size() != PAIR_CNT || err_idx != -1) begin
            n_fail++; $display("FAIL rstmid_counts: rd %0d wr %0d err at %0d", rd_q.size(), wr_q.size(), err_idx); end
        for (int i = 0; i < rd_q.size() && i < PAIR_CNT; i++) begin
            n_cmp++; if (rd_q[i] !== exp_q[i] || wr_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL rstmid_addr[%0d]: rd %0d wr %0d expected %0d", i, rd_q[i], wr_q[i], exp_q[i]); end
        end
        req = 2'b00;
    endtask

    task automatic test_idle_outen();
        do_reset();
        @(negedge clk);
        pulse = 1'b1;
        @(negedge clk);
        n_cmp++; if (wr_en !== 1'b0 || err !== 1'b1 || gnt !== 2'b00 || busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_pulse: wr_en=%b err=%b gnt=%b busy=%b expected 0/1/00/0", wr_en, err, gnt, busy); end
        pulse = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (err !== 1'b1 || gnt !== 2'b00) begin
            n_fail++; $display("FAIL idle_sticky: err=%b gnt=%b expected 1/00", err, gnt); end
    endtask

    task automatic test_back_to_back();
        bit fin;
        logic [1:0] exp_g;
        do_reset();
        lat = $urandom_range(1, 60); ntt_mode = 0;
        @(negedge clk);
        for (int r = 0; r < 5; r++) begin
            req = req | 2'($urandom_range(1, 3));
            exp_g = pick(req, last_client);
            tr.delete();
            run_job(400, 1'b0, fin);
            analyse();
            n_cmp++; if (!fin) begin n_fail++; $display("FAIL b2b_finish[%0d]: no done within 400 cycles", r); end
            n_cmp++; if (gnt_q.size() != 1 || gnt_q[0] !== exp_g || done_q.size() != 1 || done_q[0] !== exp_g) begin
                n_fail++; $display("FAIL b2b_winner[%0d]: gnt=%b done=%b expected %b", r, gnt_q[0], done_q[0], exp_g); end
            n_cmp++; if (rd_q.size() != PAIR_CNT || wr_q.size() != PAIR_CNT || err_idx != -1 || bank_bad != 0) begin
                n_fail++; $display("FAIL b2b_job[%0d]: rd %0d wr %0d err at %0d bank errors %0d", r, rd_q.size(), wr_q.size(), err_idx, bank_bad); end
            last_client = exp_g[1] ? 1 : 0;
        end
        req = 2'b00;
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        rst = 1'b1; req = 2'b00; pulse = 1'b0;
        lat = 40; ntt_mode = 0; last_client = 1;
        test_reset();
        test_single();
        test_round_robin();
        test_long_outen();
        test_timeout();
        test_reset_midjob();
        test_idle_outen();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
